// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared CP0 register numbers, field positions and exception codes
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_SR       = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int IP_LSB   = 10;
    localparam int CAUSE_BD = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // Which of the six IP/IM positions are backed by a real request source.
    function automatic logic [5:0] ip_line_mask(input int num_hwint, input int timer_en,
                                                input int timer_line);
        logic [5:0] m;
        m = '0;
        for (int i = 0; i < 6; i++) begin
            if (i < num_hwint || (timer_en != 0 && i == timer_line)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Restart address: the delay-slot instruction restarts at its branch.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        logic [31:0] word_pc;
        word_pc = {pc[31:2], 2'b00};
        return bd ? word_pc - 32'd4 : word_pc;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare interval timer with sticky match flag
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   count_we_i          load din_i into Count instead of incrementing
//   compare_we_i        load din_i into Compare and clear the pending flag
//   din_i               write data
//   count_o, compare_o  current register values
//   pending_o           timer interrupt flag
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] din_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        pending_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        pending_q, pending_d;

    always_comb begin
        count_d   = count_we_i ? din_i : count_q + 32'd1;
        compare_d = compare_we_i ? din_i : compare_q;
        pending_d = pending_q;
        // Match uses the pre-increment Count; a Compare write wins over a match.
        if (compare_we_i)              pending_d = 1'b0;
        else if (count_q == compare_q) pending_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pending_q <= pending_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/cp0_ext.sv
// rtl/cp0_ext.sv - coprocessor 0: SR/Cause/EPC/PRId/BadVAddr, interval timer, HW interrupts
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   a, din, we      mfc0/mtc0 register number, write data, write enable
//   pc, bd          M-stage PC and delay-slot flag
//   exc_valid/code  synchronous exception from M
//   bad_vaddr       faulting address for address-error exceptions
//   hw_int          external interrupt levels
//   eret            eret in M
//   int_req         take exception this cycle (combinational)
//   epc_out         current EPC
//   dout            mfc0 read data (combinational)
//   timer_pending   timer interrupt flag
module cp0_ext
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT  = 6,
    parameter int          TIMER_EN   = 1,
    parameter int          TIMER_LINE = 5,
    parameter logic [31:0] RESET_EPC  = 32'h0000_3000,
    parameter logic [31:0] PRID_VALUE = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           a,
    input  logic [31:0]          din,
    input  logic                 we,
    input  logic [31:0]          pc,
    input  logic                 bd,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          bad_vaddr,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 eret,
    output logic                 int_req,
    output logic [31:0]          epc_out,
    output logic [31:0]          dout,
    output logic                 timer_pending
);

    localparam logic [5:0] IP_MASK = ip_line_mask(NUM_HWINT, TIMER_EN, TIMER_LINE);

    logic [31:0] sr_q, sr_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] bva_q, bva_d;
    logic [31:0] count_w, compare_w;
    logic        pending_w;
    logic [5:0]  ip_vec;
    logic        irq;
    logic        wr_ok;

    assign wr_ok = we & ~int_req;

    if (TIMER_EN != 0) begin : g_timer
        cp0_timer u_timer (
            .clk          (clk),
            .reset        (reset),
            .count_we_i   (wr_ok && a == CP0_COUNT),
            .compare_we_i (wr_ok && a == CP0_COMPARE),
            .din_i        (din),
            .count_o      (count_w),
            .compare_o    (compare_w),
            .pending_o    (pending_w)
        );
    end else begin : g_no_timer
        assign count_w   = '0;
        assign compare_w = '0;
        assign pending_w = 1'b0;
    end

    always_comb begin
        ip_vec = '0;
        ip_vec[NUM_HWINT-1:0] = hw_int;
        if (TIMER_EN != 0) ip_vec[TIMER_LINE] = ip_vec[TIMER_LINE] | pending_w;
        ip_vec = ip_vec & IP_MASK;
    end

    assign irq     = (|(ip_vec & sr_q[IP_LSB +: 6])) & sr_q[SR_IE] & ~sr_q[SR_EXL];
    assign int_req = ~reset & (irq | exc_valid);

    always_comb begin
        sr_d    = sr_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        bva_d   = bva_q;
        cause_d[IP_LSB +: 6] = ip_vec;
        if (int_req) begin
            // Exception entry overrides eret and any mtc0 in the same cycle.
            sr_d[SR_EXL]      = 1'b1;
            epc_d             = epc_of(pc, bd);
            cause_d[CAUSE_BD] = bd;
            cause_d[6:2]      = irq ? EXC_INT : exc_code;
            if (!irq && (exc_code == EXC_ADEL || exc_code == EXC_ADES)) bva_d = bad_vaddr;
        end else begin
            if (we && a == CP0_SR)  sr_d  = din;
            if (eret)               sr_d[SR_EXL] = 1'b0;
            if (we && a == CP0_EPC) epc_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= RESET_EPC;
            bva_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            bva_q   <= bva_d;
        end
    end

    always_comb begin
        dout = '0;
        case (a)
            CP0_BADVADDR: dout = bva_q;
            CP0_COUNT:    dout = count_w;
            CP0_COMPARE:  dout = compare_w;
            CP0_SR:       dout = sr_q;
            CP0_CAUSE:    dout = cause_q;
            CP0_EPC:      dout = epc_q;
            CP0_PRID:     dout = PRID_VALUE;
            default:      dout = '0;
        endcase
    end

    assign epc_out       = epc_q;
    assign timer_pending = pending_w;

endmodule

// File: tb/tb_cp0_ext.sv
// tb/tb_cp0_ext.sv - scoreboard testbench for cp0_ext
module tb_cp0_ext;

    localparam int          NHW   = 6;
    localparam int          TLINE = 5;
    localparam logic [31:0] REPC  = 32'h0000_3000;
    localparam logic [31:0] PRID  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  a = '0;
    logic [31:0] din = '0;
    logic        we = 1'b0;
    logic [31:0] pc = '0;
    logic        bd = 1'b0;
    logic        exc_valid = 1'b0;
    logic [4:0]  exc_code = '0;
    logic [31:0] bad_vaddr = '0;
    logic [5:0]  hw_int = '0;
    logic        eret = 1'b0;
    logic        int_req;
    logic [31:0] epc_out;
    logic [31:0] dout;
    logic        timer_pending;

    always #5 clk = ~clk;

    cp0_ext #(
        .NUM_HWINT(NHW), .TIMER_EN(1), .TIMER_LINE(TLINE),
        .RESET_EPC(REPC), .PRID_VALUE(PRID)
    ) dut (
        .clk(clk), .reset(reset), .a(a), .din(din), .we(we), .pc(pc), .bd(bd),
        .exc_valid(exc_valid), .exc_code(exc_code), .bad_vaddr(bad_vaddr),
        .hw_int(hw_int), .eret(eret), .int_req(int_req), .epc_out(epc_out),
        .dout(dout), .timer_pending(timer_pending)
    );

    typedef struct {
        bit          chk;
        bit          ireq;
        logic [31:0] rd;
        logic [31:0] epc;
        bit          tp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Architectural state of the reference model.
    bit [31:0] m_sr, m_cause, m_epc, m_bva, m_count, m_cmp;
    bit        m_tp;
    bit        m_known = 1'b0;

    function automatic bit [31:0] m_read(input bit [4:0] ra);
        case (ra)
            5'd8:    return m_bva;
            5'd9:    return m_count;
            5'd11:   return m_cmp;
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic cyc(input bit rst, input bit [4:0] ra, input bit [31:0] rdin, input bit rwe,
                       input bit [31:0] rpc, input bit rbd, input bit rexc, input bit [4:0] rcode,
                       input bit [31:0] rbva, input bit [5:0] rhw, input bit reret);
        exp_t      e;
        bit [5:0]  pend;
        bit        takes_irq, entry;
        bit [31:0] restart;
        @(negedge clk);
        #1;
        reset = rst; a = ra; din = rdin; we = rwe; pc = rpc; bd = rbd;
        exc_valid = rexc; exc_code = rcode; bad_vaddr = rbva; hw_int = rhw; eret = reret;

        pend = rhw;
        if (m_tp) pend[TLINE] = 1'b1;
        takes_irq = ((pend & m_sr[15:10]) != 0) && m_sr[0] && !m_sr[1];
        entry = !rst && (takes_irq || rexc);

        e.chk = m_known; e.ireq = entry; e.rd = m_read(ra); e.epc = m_epc; e.tp = m_tp;
        q.push_back(e);

        if (rst) begin
            m_sr = 0; m_cause = 0; m_epc = REPC; m_bva = 0; m_count = 0; m_cmp = 0; m_tp = 0;
        end else begin
            m_cause[15:10] = pend;
            if (m_count == m_cmp) m_tp = 1'b1;
            m_count = m_count + 1;
            if (entry) begin
                restart = (rpc / 4) * 4;
                if (rbd) restart = restart - 4;
                m_epc = restart;
                m_sr[1] = 1'b1;
                m_cause[31] = rbd;
                m_cause[6:2] = takes_irq ? 5'd0 : rcode;
                if (!takes_irq && (rcode == 5'd4 || rcode == 5'd5)) m_bva = rbva;
            end else begin
                if (rwe) begin
                    case (ra)
                        5'd9:  m_count = rdin;
                        5'd11: begin m_cmp = rdin; m_tp = 1'b0; end
                        5'd12: m_sr = rdin;
                        5'd14: m_epc = rdin;
                        default: ;
                    endcase
                end
                if (reret) m_sr[1] = 1'b0;
            end
        end
        m_known = 1'b1;
    endtask

    task automatic rd(input bit [4:0] ra);
        cyc(0, ra, 0, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input bit [4:0] ra, input bit [31:0] d);
        cyc(0, ra, d, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_eret();
        cyc(0, 5'd12, 0, 0, 32'h100, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT outputs of each cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    check32("int_req", {31'd0, int_req}, {31'd0, e.ireq});
                    check32("dout", dout, e.rd);
                    check32("epc_out", epc_out, e.epc);
                    check32("timer_pending", {31'd0, timer_pending}, {31'd0, e.tp});
                end
            end
        end
    end

    initial begin
        bit [4:0]  addrs[10];
        bit [4:0]  ra;
        bit [31:0] d;
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd10, 5'd0, 5'd12};

        repeat (3) cyc(1, 5'd14, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rd(5'd12); rd(5'd13); rd(5'd8); rd(5'd15);

        // Enabled hardware interrupt, then masked by EXL.
        wr(5'd12, 32'h0000_FC01);
        cyc(0, 5'd13, 0, 0, 32'h1000, 0, 0, 0, 0, 6'b000100, 0);
        rd(5'd13); rd(5'd12);
        cyc(0, 5'd12, 0, 0, 32'h1004, 0, 0, 0, 0, 6'b000100, 0);
        do_eret(); rd(5'd12);

        // Address error in a delay slot.
        cyc(0, 5'd14, 0, 0, 32'h3008, 1, 1, 5'd4, 32'h0000_1235, 0, 0);
        rd(5'd14); rd(5'd13); rd(5'd8);

        // Interrupt beats a simultaneous exception.
        do_eret();
        cyc(0, 5'd13, 0, 0, 32'h2000, 0, 1, 5'd10, 32'hDEAD_BEEF, 6'b000001, 0);
        rd(5'd13); rd(5'd8);

        // Timer match raises an interrupt; a Compare write clears the flag.
        do_eret();
        wr(5'd9, 32'd0);
        wr(5'd11, 32'd20);
        wr(5'd12, 32'h0000_8001);
        repeat (26) rd(5'd9);
        rd(5'd13);
        wr(5'd11, 32'd1000);
        rd(5'd11);

        // eret loses to an enabled interrupt, then eret alone clears EXL.
        wr(5'd12, 32'h0000_FC01);
        cyc(0, 5'd12, 0, 0, 32'h6000, 0, 0, 0, 0, 6'b000001, 1);
        rd(5'd12); rd(5'd14);
        do_eret(); rd(5'd12);

        // mtc0 EPC dropped during an exception, then reset mid-handler.
        cyc(0, 5'd14, 32'h4000, 1, 32'h5000, 0, 1, 5'd8, 0, 0, 0);
        rd(5'd14);
        cyc(1, 5'd14, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rd(5'd14); rd(5'd12); rd(5'd13);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            ra = addrs[$urandom_range(0, 9)];
            d  = $urandom;
            if (ra == 5'd12 && $urandom_range(0, 1) == 0) d[1:0] = 2'b01;
            if (ra == 5'd11 && $urandom_range(0, 1) == 0) d = m_count + $urandom_range(1, 30);
            if (ra == 5'd9 && $urandom_range(0, 1) == 0)  d = m_cmp - $urandom_range(1, 30);
            cyc(($urandom_range(0, 299) == 0), ra, d, ($urandom_range(0, 2) == 0),
                $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
                5'($urandom), $urandom,
                ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0,
                ($urandom_range(0, 9) == 0));
        end
        rd(5'd0);

        repeat (3) @(negedge clk);
        #5;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
